mul_issue_sequencer: RTL and testbench
======================================

# mul_issue_sequencer

Multi-cycle issue/retire stage wrapped around the combinational 32x32 multiplier in the LEGv8 datapath. It accepts a multiply request from register read over a valid/ready handshake and holds the operands stable on the multiplier inputs for a fixed number of cycles, so the multiplier can be constrained as a multicycle path. It then captures the 64-bit product and presents it with its destination register to writeback over a second valid/ready handshake.

## Interface
- LATENCY, default 4: cycles operands are held before the product is captured; legal 1..15.
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous reset, active-low.
- in_valid  input  1  request valid.
- in_ready  output  1  stage can accept a request.
- in_a  input  64  operand A; only bits [31:0] are used.
- in_b  input  64  operand B; only bits [31:0] are used.
- in_rd  input  5  destination register number.
- in_signed  input  1  signed multiply request; honoured only with MUL_SIGNED_EN.
- mul_a  output  64  registered operand A to the multiplier.
- mul_b  output  64  registered operand B to the multiplier.
- mul_product  input  64  multiplier result.
- out_valid  output  1  result valid.
- out_ready  input  1  writeback accepts the result.
- out_result  output  64  captured product.
- out_rd  output  5  destination register of out_result.
- busy  output  1  high in WAIT or DONE.

## Operation
- FSM states are IDLE, WAIT and DONE.
- in_ready = rst_n && (state==IDLE || (state==DONE && out_ready)). The combinational path from out_ready to in_ready is intentional.
- Accept occurs on in_valid && in_ready at a rising edge. On accept:
  - mul_a <= {32'b0, opA32} and mul_b <= {32'b0, opB32}.
  - rd_q <= in_rd and neg_q <= sign-fix flag.
  - cnt <= LATENCY-1, and the state becomes WAIT.
- WAIT with cnt != 0: cnt decrements. The in_a, in_b and in_rd ports are ignored.
- WAIT with cnt == 0:
  - out_result <= neg_q ? -mul_product : mul_product.
  - out_rd <= rd_q, and the state becomes DONE.
- DONE: out_valid=1, and out_result and out_rd are held stable.
  - out_ready=1 with no new accept: the state becomes IDLE.
  - out_ready=1 with a simultaneous accept: a new request is latched and the state goes directly to WAIT (back-to-back).
  - out_ready=0: the state stays in DONE, and in_ready=0.
- mul_a and mul_b hold their last value in IDLE and DONE.
- Arithmetic: the upper 32 bits of in_a and in_b are discarded. The product is a 64-bit unsigned result of the 32-bit operands, and no overflow is possible.

## Timing
- Reset (rst_n low at an edge):
  - The state becomes IDLE; cnt, mul_a, mul_b, out_result, out_rd, rd_q and neg_q become 0.
  - out_valid=0 and busy=0.
  - in_ready=0 while rst_n is low.
- Reset mid-operation (in WAIT or DONE) abandons the request. No result is ever presented.
- For an accept at edge N:
  - The product is captured at edge N+LATENCY.
  - out_valid is high from edge N+LATENCY onward.
  - The multiplier inputs are stable from edge N+1 through edge N+LATENCY.
- Sustained throughput with out_ready held high is one result per LATENCY+1 cycles.
- out_valid never drops without out_ready, and out_result never changes while out_valid=1 && out_ready=0.

## Configuration
- MUL_SIGNED_EN defined:
  - When in_signed=1, opA32 = |in_a[31:0]| and opB32 = |in_b[31:0]| as two's-complement values.
  - neg_q = in_a[31]^in_b[31], and the 64-bit result is negated.
  - |-2^31| = 0x8000_0000 is handled as unsigned.
  - When in_signed=0, behaviour is unsigned.
- MUL_SIGNED_EN undefined: in_signed is ignored, opA32 = in_a[31:0], opB32 = in_b[31:0] and neg_q=0. No negation logic is synthesised.

## Test plan
- Reset then idle: rst_n=0 for 2 cycles, then released. Required: out_valid=0, busy=0, in_ready=0 during reset and in_ready=1 after release.
- Basic unsigned, LATENCY=4: a=0xFFFF_FFFF_0000_0003, b=5, rd=7, accept at edge N. Required: out_valid rises at edge N+4, out_result=15, out_rd=7.
- Backpressure: hold out_ready=0 for 6 cycles after out_valid, with in_valid held high. Required: out_result stays stable, in_ready=0, and no second accept occurs. On out_ready=1 the new request is accepted in the same cycle.
- Back-to-back with LATENCY=1 and out_ready=1: requests 2×3 then 4×5. Required: results 6 then 20, with out_valid high one cycle in every two.
- MUL_SIGNED_EN, in_signed=1: a=0xFFFF_FFFE (−2), b=3. Required: out_result=0xFFFF_FFFF_FFFF_FFFA. Also a=b=0x8000_0000. Required: out_result=0x4000_0000_0000_0000.
- Reset mid-WAIT: pull rst_n low 2 cycles after accept. Required: out_valid never asserts, and after release the state is IDLE with in_ready=1.

Source files
------------

// File: rtl/mul_issue_sequencer_if.sv
// Handshake bundle for mul_issue_sequencer: request from register read, operand/product
// connection to the combinational multiplier, and result toward writeback.
interface mul_issue_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic [4:0]  in_rd;
  logic        in_signed;
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic [63:0] mul_product;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;
  logic [4:0]  out_rd;

  // The sequencer itself.
  modport slave (
    input  in_valid, in_a, in_b, in_rd, in_signed, mul_product, out_ready,
    output in_ready, mul_a, mul_b, out_valid, out_result, out_rd
  );

  // Surroundings: register read, the multiplier and writeback.
  modport master (
    output in_valid, in_a, in_b, in_rd, in_signed, mul_product, out_ready,
    input  in_ready, mul_a, mul_b, out_valid, out_result, out_rd
  );
endinterface

// File: rtl/mul_issue_sequencer.sv
// Multi-cycle issue/retire stage around a combinational 32x32 multiplier.
// Define MUL_SIGNED_EN to add sign-magnitude handling of signed requests.
module mul_issue_sequencer #(
  parameter int unsigned LATENCY = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mul_issue_sequencer_if.slave   bus,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] mul_a_q, mul_b_q;
  logic [63:0] result_q;
  logic [4:0]  rd_q, out_rd_q;
  logic        accept;
  logic        capture;
  logic [31:0] op_a, op_b;
  logic [63:0] product_fixed;
  logic        unused_bits;

  // The multiplier only ever sees the low words.
  assign unused_bits = ^{bus.in_a[63:32], bus.in_b[63:32], bus.in_signed};

`ifdef MUL_SIGNED_EN
  logic neg_q;

  // Signed requests are multiplied as magnitudes; the sign is reapplied on capture.
  always_comb begin
    op_a = bus.in_a[31:0];
    op_b = bus.in_b[31:0];
    if (bus.in_signed && bus.in_a[31]) op_a = ~bus.in_a[31:0] + 32'd1;
    if (bus.in_signed && bus.in_b[31]) op_b = ~bus.in_b[31:0] + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      neg_q <= 1'b0;
    end else if (accept) begin
      neg_q <= bus.in_signed & (bus.in_a[31] ^ bus.in_b[31]);
    end
  end

  assign product_fixed = neg_q ? (~bus.mul_product + 64'd1) : bus.mul_product;
`else
  assign op_a          = bus.in_a[31:0];
  assign op_b          = bus.in_b[31:0];
  assign product_fixed = bus.mul_product;
`endif

  // out_ready feeds in_ready combinationally so DONE can hand over to a new request.
  assign bus.in_ready = rst_n && ((state_q == IDLE) || (state_q == DONE && bus.out_ready));
  assign accept       = bus.in_valid && bus.in_ready;
  assign capture      = (state_q == WAIT) && (cnt_q == 4'd0);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every output of this block is given a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = WAIT;
          cnt_d   = 4'(LATENCY - 1);
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) cnt_d   = cnt_q - 4'd1;
        else               state_d = DONE;
      end
      DONE: begin
        if (accept) begin
          state_d = WAIT;
          cnt_d   = 4'(LATENCY - 1);
        end else if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the datapath registers are cleared on reset too, so the multiplier inputs
  // and the result bus never carry stale data from an abandoned request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mul_a_q  <= 64'd0;
      mul_b_q  <= 64'd0;
      rd_q     <= 5'd0;
      result_q <= 64'd0;
      out_rd_q <= 5'd0;
    end else begin
      if (accept) begin
        mul_a_q <= {32'd0, op_a};
        mul_b_q <= {32'd0, op_b};
        rd_q    <= bus.in_rd;
      end
      if (capture) begin
        result_q <= product_fixed;
        out_rd_q <= rd_q;
      end
    end
  end

  assign bus.mul_a      = mul_a_q;
  assign bus.mul_b      = mul_b_q;
  assign bus.out_valid  = (state_q == DONE);
  assign bus.out_result = result_q;
  assign bus.out_rd     = out_rd_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_mul_issue_sequencer.sv
// Self-checking bench: two sequencers (LATENCY 4 and 1) share one stimulus stream and
// are each compared every cycle against a transaction-level reference model.
module tb_mul_issue_sequencer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [63:0] in_a, in_b;
  logic [4:0]  in_rd;
  logic        in_signed;
  logic        out_ready;

  mul_issue_sequencer_if bus0 ();
  mul_issue_sequencer_if bus1 ();
  logic busy0, busy1;

  mul_issue_sequencer #(.LATENCY(4)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0), .busy(busy0));
  mul_issue_sequencer #(.LATENCY(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1), .busy(busy1));

  assign bus0.in_valid  = in_valid;
  assign bus0.in_a      = in_a;
  assign bus0.in_b      = in_b;
  assign bus0.in_rd     = in_rd;
  assign bus0.in_signed = in_signed;
  assign bus0.out_ready = out_ready;
  assign bus1.in_valid  = in_valid;
  assign bus1.in_a      = in_a;
  assign bus1.in_b      = in_b;
  assign bus1.in_rd     = in_rd;
  assign bus1.in_signed = in_signed;
  assign bus1.out_ready = out_ready;

  // Combinational multiplier stand-in.
  assign bus0.mul_product = {32'd0, bus0.mul_a[31:0]} * {32'd0, bus0.mul_b[31:0]};
  assign bus1.mul_product = {32'd0, bus1.mul_a[31:0]} * {32'd0, bus1.mul_b[31:0]};

  logic        o_ready [2];
  logic        o_valid [2];
  logic        o_busy  [2];
  logic [63:0] o_res   [2];
  logic [4:0]  o_rd    [2];
  logic [63:0] o_ma    [2];
  logic [63:0] o_mb    [2];

  assign o_ready[0] = bus0.in_ready;   assign o_ready[1] = bus1.in_ready;
  assign o_valid[0] = bus0.out_valid;  assign o_valid[1] = bus1.out_valid;
  assign o_busy[0]  = busy0;           assign o_busy[1]  = busy1;
  assign o_res[0]   = bus0.out_result; assign o_res[1]   = bus1.out_result;
  assign o_rd[0]    = bus0.out_rd;     assign o_rd[1]    = bus1.out_rd;
  assign o_ma[0]    = bus0.mul_a;      assign o_ma[1]    = bus1.mul_a;
  assign o_mb[0]    = bus0.mul_b;      assign o_mb[1]    = bus1.mul_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: a request accepted at edge N yields its result at edge N+latency.
  int          edge_n = 0;
  logic        m_init = 1'b0;
  logic        m_pend [2];
  int          m_acc  [2];
  logic        m_resv [2];
  logic [63:0] m_pres [2];
  logic [4:0]  m_prd  [2];
  logic [63:0] m_res  [2];
  logic [4:0]  m_rd   [2];
  logic [63:0] m_ma   [2];
  logic [63:0] m_mb   [2];

  function automatic int lat_of(input int m);
    return (m == 0) ? 4 : 1;
  endfunction

  function automatic logic [63:0] ref_operand(input logic [63:0] x, input logic s);
    logic [31:0] v;
    v = x[31:0];
`ifdef MUL_SIGNED_EN
    if (s && v[31]) v = 32'd0 - v;
`else
    if (s) v = x[31:0];
`endif
    return {32'd0, v};
  endfunction

  function automatic logic [63:0] ref_product(input logic [63:0] a, input logic [63:0] b,
                                              input logic s);
    logic signed [63:0] sa, sb;
    sa = {{32{a[31]}}, a[31:0]};
    sb = {{32{b[31]}}, b[31:0]};
`ifdef MUL_SIGNED_EN
    if (s) return sa * sb;
`else
    if (s && (sa != sb)) return {32'd0, a[31:0]} * {32'd0, b[31:0]};
`endif
    return {32'd0, a[31:0]} * {32'd0, b[31:0]};
  endfunction

  task automatic cycle();
    logic acc [2];
    logic exp_rdy;
    #1;
    for (int m = 0; m < 2; m++) begin
      exp_rdy = rst_n && ((!m_pend[m] && !m_resv[m]) || (m_resv[m] && out_ready));
      check($sformatf("in_ready%0d", m), o_ready[m], exp_rdy);
      if (m_init) begin
        check($sformatf("out_valid%0d", m), o_valid[m], m_resv[m]);
        check($sformatf("busy%0d", m), o_busy[m], m_pend[m] | m_resv[m]);
        check($sformatf("out_result%0d", m), o_res[m], m_res[m]);
        check($sformatf("out_rd%0d", m), o_rd[m], m_rd[m]);
        check($sformatf("mul_a%0d", m), o_ma[m], m_ma[m]);
        check($sformatf("mul_b%0d", m), o_mb[m], m_mb[m]);
      end
      acc[m] = in_valid && exp_rdy;
    end
    @(posedge clk);
    edge_n++;
    for (int m = 0; m < 2; m++) begin
      if (!rst_n) begin
        m_pend[m] = 1'b0; m_resv[m] = 1'b0; m_acc[m] = 0;
        m_res[m]  = '0;   m_rd[m]   = '0;
        m_ma[m]   = '0;   m_mb[m]   = '0;
        m_pres[m] = '0;   m_prd[m]  = '0;
      end else begin
        if (m_resv[m] && out_ready) m_resv[m] = 1'b0;
        if (m_pend[m] && edge_n == m_acc[m] + lat_of(m)) begin
          m_pend[m] = 1'b0;
          m_resv[m] = 1'b1;
          m_res[m]  = m_pres[m];
          m_rd[m]   = m_prd[m];
        end
        if (acc[m]) begin
          m_pend[m] = 1'b1;
          m_acc[m]  = edge_n;
          m_ma[m]   = ref_operand(in_a, in_signed);
          m_mb[m]   = ref_operand(in_b, in_signed);
          m_pres[m] = ref_product(in_a, in_b, in_signed);
          m_prd[m]  = in_rd;
        end
      end
    end
    if (!rst_n) m_init = 1'b1;
    #1;
  endtask

  task automatic request(input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd,
                         input logic s);
    in_valid = 1'b1; in_a = a; in_b = b; in_rd = rd; in_signed = s;
  endtask

  task automatic idle_cycles(input int n);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < n; i++) cycle();
  endtask

  function automatic logic [63:0] pick_operand();
    logic [31:0] lo;
    case ($urandom_range(0, 7))
      0: lo = 32'h0000_0000;
      1: lo = 32'h0000_0001;
      2: lo = 32'h7FFF_FFFF;
      3: lo = 32'h8000_0000;
      4: lo = 32'hFFFF_FFFF;
      default: lo = $urandom;
    endcase
    return {32'($urandom), lo};
  endfunction

  int   vcount;
  logic seen;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_rd = '0;
    in_signed = 1'b0; out_ready = 1'b1;

    // Reset, then idle.
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();
    check("idle_in_ready", o_ready[0], 1'b1);
    check("idle_busy", o_busy[0], 1'b0);

    // Basic unsigned, upper operand bits discarded.
    request(64'hFFFF_FFFF_0000_0003, 64'd5, 5'd7, 1'b0);
    cycle();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    check("basic_not_yet_valid", o_valid[0], 1'b0);
    out_ready = 1'b0;
    request(64'd9, 64'd11, 5'd3, 1'b0);
    cycle();
    check("basic_valid", o_valid[0], 1'b1);
    check("basic_result", o_res[0], 64'd15);
    check("basic_rd", o_rd[0], 5'd7);

    // Backpressure with a request waiting.
    for (int i = 0; i < 6; i++) begin
      cycle();
      check("bp_result_stable", o_res[0], 64'd15);
      check("bp_valid_held", o_valid[0], 1'b1);
    end
    out_ready = 1'b1;
    cycle();
    check("bp_handover_busy", o_busy[0], 1'b1);
    check("bp_handover_valid", o_valid[0], 1'b0);
    check("bp_handover_mul_a", o_ma[0], 64'd9);
    idle_cycles(8);

    // Back-to-back on the LATENCY=1 instance.
    request(64'd2, 64'd3, 5'd1, 1'b0);
    cycle();
    request(64'd4, 64'd5, 5'd2, 1'b0);
    cycle();
    check("b2b_first_valid", o_valid[1], 1'b1);
    check("b2b_first_result", o_res[1], 64'd6);
    cycle();
    check("b2b_gap", o_valid[1], 1'b0);
    cycle();
    check("b2b_second_result", o_res[1], 64'd20);
    vcount = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (o_valid[1]) vcount++;
    end
    check("b2b_throughput", 64'(vcount), 64'd5);
    idle_cycles(8);

    // Signed requests (unsigned interpretation when the feature is compiled out).
    request(64'h0000_0000_FFFF_FFFE, 64'd3, 5'd4, 1'b1);
    cycle();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
`ifdef MUL_SIGNED_EN
    check("signed_neg2x3", o_res[0], 64'hFFFF_FFFF_FFFF_FFFA);
`else
    check("signed_neg2x3", o_res[0], 64'h0000_0002_FFFF_FFFA);
`endif
    idle_cycles(2);
    request(64'h8000_0000, 64'h8000_0000, 5'd5, 1'b1);
    cycle();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    check("signed_min_sq", o_res[0], 64'h4000_0000_0000_0000);
    idle_cycles(4);

    // Reset in the middle of WAIT abandons the request.
    request(64'd6, 64'd7, 5'd9, 1'b0);
    cycle();
    in_valid = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cycle();
      seen |= o_valid[0];
    end
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      seen |= o_valid[0];
    end
    check("midwait_no_result", seen, 1'b0);
    check("midwait_in_ready", o_ready[0], 1'b1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 800; i++) begin
      rst_n     = ($urandom_range(0, 149) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_a      = pick_operand();
      in_b      = pick_operand();
      in_rd     = 5'($urandom);
      in_signed = 1'($urandom);
      cycle();
    end
    rst_n = 1'b1;
    idle_cycles(8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
